// File: rtl/sr_latch_ctrl.sv
// -----------------------------------------------------------------------------
// sr_latch_ctrl
//
// Sequencer that owns the S/R inputs of one gate-level SR latch and shares it
// between a set requester and a clear requester. Each granted operation drives
// a PULSE_W-cycle pulse on S (set) or R (clear), holds S=R=0 for GAP_W settle
// cycles, then samples the latch Q/NQ feedback for one cycle while it
// acknowledges the requester. A feedback mismatch raises a sticky err flag.
//
// Parameters
//   PULSE_W  cycles S or R is held high per operation (1..15)
//   GAP_W    settle cycles with S=R=0 before the feedback check (0..15)
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   set_req  level request to drive Q=1, held until set_ack
//   clr_req  level request to drive Q=0, held until clr_ack
//   err_clr  synchronous clear of err
//   lat_q    latch Q feedback
//   lat_nq   latch NQ feedback
//   lat_s    latch S drive (registered)
//   lat_r    latch R drive (registered)
//   set_ack  one-cycle completion strobe for a set operation
//   clr_ack  one-cycle completion strobe for a clear operation
//   busy     high in every state except IDLE
//   err      sticky feedback-mismatch flag
// -----------------------------------------------------------------------------
module sr_latch_ctrl #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    input  logic err_clr,
    input  logic lat_q,
    input  logic lat_nq,
    output logic lat_s,
    output logic lat_r,
    output logic set_ack,
    output logic clr_ack,
    output logic busy,
    output logic err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    // Counter loads are "cycles minus one" so the counter reaching zero marks
    // the last cycle of the phase. GAP_W=0 never loads the gap value.
    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_W - 1);
    localparam logic [3:0] GAP_LOAD   = (GAP_W > 0) ? 4'(GAP_W - 1) : 4'd0;

    state_t     state;
    logic [3:0] cnt;
    logic       grant_set;   // 1: current operation is a set, 0: a clear
    logic       last_set;    // 1: last completed grant was a set
    logic       pick_set;
    logic       mismatch;

    // Round-robin on a tie: grant the opposite of the last completed grant.
    always_comb begin
        pick_set = set_req && (!clr_req || !last_set);
    end

    // A healthy latch shows Q equal to the commanded value and NQ as its
    // complement; Q==NQ flags a latch that is stuck or was driven illegally.
    always_comb begin
        mismatch = (lat_q != grant_set) || (lat_q == lat_nq);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            grant_set <= 1'b0;
            last_set  <= 1'b0;
            lat_s     <= 1'b0;
            lat_r     <= 1'b0;
            set_ack   <= 1'b0;
            clr_ack   <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // A mismatch in CHECK below overrides this, so set wins over clear.
            if (err_clr) begin
                err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (set_req || clr_req) begin
                        grant_set <= pick_set;
                        cnt       <= PULSE_LOAD;
                        lat_s     <= pick_set;
                        lat_r     <= !pick_set;
                        busy      <= 1'b1;
                        state     <= PULSE;
                    end
                end

                PULSE: begin
                    if (cnt == 4'd0) begin
                        lat_s <= 1'b0;
                        lat_r <= 1'b0;
                        if (GAP_W == 0) begin
                            set_ack <= grant_set;
                            clr_ack <= !grant_set;
                            state   <= CHECK;
                        end else begin
                            cnt   <= GAP_LOAD;
                            state <= SETTLE;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                SETTLE: begin
                    if (cnt == 4'd0) begin
                        set_ack <= grant_set;
                        clr_ack <= !grant_set;
                        state   <= CHECK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                CHECK: begin
                    // Feedback is sampled only here; glitches elsewhere are ignored.
                    if (mismatch) begin
                        err <= 1'b1;
                    end
                    set_ack  <= 1'b0;
                    clr_ack  <= 1'b0;
                    busy     <= 1'b0;
                    last_set <= grant_set;
                    state    <= IDLE;
                end

                default: begin
                    lat_s   <= 1'b0;
                    lat_r   <= 1'b0;
                    set_ack <= 1'b0;
                    clr_ack <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sr_latch_ctrl
//
// Directed bench for sr_latch_ctrl. Instance "a" uses the default timing
// (PULSE_W=2, GAP_W=1); instance "b" uses PULSE_W=1, GAP_W=0. Each instance
// drives a behavioural SR latch whose feedback can be forced to a stuck
// Q=0/NQ=0 fault. Outputs are sampled 1 time unit after the rising edge.
// Output vectors are packed as {lat_s, lat_r, set_ack, clr_ack, busy, err}.
// -----------------------------------------------------------------------------
module tb_sr_latch_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic a_set_req = 1'b0, a_clr_req = 1'b0, a_err_clr = 1'b0;
    logic a_lat_q, a_lat_nq, a_lat_s, a_lat_r, a_set_ack, a_clr_ack, a_busy, a_err;
    logic b_set_req = 1'b0, b_clr_req = 1'b0, b_err_clr = 1'b0;
    logic b_lat_q, b_lat_nq, b_lat_s, b_lat_r, b_set_ack, b_clr_ack, b_busy, b_err;

    logic a_q = 1'b0, b_q = 1'b0;
    logic a_stuck = 1'b0;

    logic [5:0] a_vec, b_vec;
    assign a_vec = {a_lat_s, a_lat_r, a_set_ack, a_clr_ack, a_busy, a_err};
    assign b_vec = {b_lat_s, b_lat_r, b_set_ack, b_clr_ack, b_busy, b_err};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural SR latches; the stored value survives controller reset.
    always @(a_lat_s or a_lat_r) begin
        if (a_lat_s) a_q = 1'b1;
        else if (a_lat_r) a_q = 1'b0;
    end
    always @(b_lat_s or b_lat_r) begin
        if (b_lat_s) b_q = 1'b1;
        else if (b_lat_r) b_q = 1'b0;
    end
    assign a_lat_q  = a_stuck ? 1'b0 : a_q;
    assign a_lat_nq = a_stuck ? 1'b0 : ~a_q;
    assign b_lat_q  = b_q;
    assign b_lat_nq = ~b_q;

    sr_latch_ctrl u_a (
        .clk(clk), .rst_n(rst_n),
        .set_req(a_set_req), .clr_req(a_clr_req), .err_clr(a_err_clr),
        .lat_q(a_lat_q), .lat_nq(a_lat_nq),
        .lat_s(a_lat_s), .lat_r(a_lat_r),
        .set_ack(a_set_ack), .clr_ack(a_clr_ack),
        .busy(a_busy), .err(a_err)
    );

    sr_latch_ctrl #(.PULSE_W(1), .GAP_W(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .set_req(b_set_req), .clr_req(b_clr_req), .err_clr(b_err_clr),
        .lat_q(b_lat_q), .lat_nq(b_lat_nq),
        .lat_s(b_lat_s), .lat_r(b_lat_r),
        .set_ack(b_set_ack), .clr_ack(b_clr_ack),
        .busy(b_busy), .err(b_err)
    );

    // Expected output vector in cycle k of an operation whose request was
    // sampled in IDLE at cycle 0 (pulse cycles 1..p, ack cycle p+g+1).
    function automatic logic [5:0] exp_op(int k, int p, int g, bit is_set, bit e);
        bit s, ack, bsy;
        s   = (k >= 1) && (k <= p);
        ack = (k == p + g + 1);
        bsy = (k >= 1) && (k <= p + g + 1);
        return {is_set & s, !is_set & s, is_set & ack, !is_set & ack, bsy, e};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (a_vec !== 6'b0) begin
            n_fail++; $display("FAIL reset_a got %b want %b", a_vec, 6'b0);
        end
        n_checks++;
        if (b_vec !== 6'b0) begin
            n_fail++; $display("FAIL reset_b got %b want %b", b_vec, 6'b0);
        end
        step();
        step();
        n_checks++;
        if (a_vec !== 6'b0) begin
            n_fail++; $display("FAIL reset_hold_a got %b want %b", a_vec, 6'b0);
        end
        rst_n = 1'b1;
        step();
    endtask

    // Set then clear on instance a; a Q/NQ glitch during the clear pulse must
    // not be sampled.
    task automatic test_basic();
        logic [5:0] e;
        a_set_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            e = exp_op(k, 2, 1, 1'b1, 1'b0);
            n_checks++;
            if (a_vec !== e) begin
                n_fail++; $display("FAIL basic_set k=%0d got %b want %b", k, a_vec, e);
            end
            if (k == 4) a_set_req = 1'b0;
        end
        n_checks++;
        if (a_lat_q !== 1'b1) begin
            n_fail++; $display("FAIL basic_set_q got %b want 1", a_lat_q);
        end
        a_clr_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            e = exp_op(k, 2, 1, 1'b0, 1'b0);
            n_checks++;
            if (a_vec !== e) begin
                n_fail++; $display("FAIL basic_clr k=%0d got %b want %b", k, a_vec, e);
            end
            a_stuck = (k == 1 || k == 2);
            if (k == 4) a_clr_req = 1'b0;
        end
        n_checks++;
        if (a_lat_q !== 1'b0) begin
            n_fail++; $display("FAIL basic_clr_q got %b want 0", a_lat_q);
        end
    endtask

    task automatic test_fast();
        logic [5:0] e;
        b_set_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            e = exp_op(k, 1, 0, 1'b1, 1'b0);
            n_checks++;
            if (b_vec !== e) begin
                n_fail++; $display("FAIL fast_set k=%0d got %b want %b", k, b_vec, e);
            end
            if (k == 2) b_set_req = 1'b0;
        end
        b_clr_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            e = exp_op(k, 1, 0, 1'b0, 1'b0);
            n_checks++;
            if (b_vec !== e) begin
                n_fail++; $display("FAIL fast_clr k=%0d got %b want %b", k, b_vec, e);
            end
            if (k == 2) b_clr_req = 1'b0;
        end
    endtask

    // Both requests held: set first (last_grant=clear after reset), then
    // clear; a second tie must grant set again.
    task automatic test_tie();
        logic [5:0] e;
        for (int r = 0; r < 2; r++) begin
            a_set_req = 1'b1;
            a_clr_req = 1'b1;
            for (int k = 1; k <= 10; k++) begin
                step();
                e = exp_op(k, 2, 1, 1'b1, 1'b0) | exp_op(k - 5, 2, 1, 1'b0, 1'b0);
                n_checks++;
                if (a_vec !== e) begin
                    n_fail++; $display("FAIL tie r=%0d k=%0d got %b want %b", r, k, a_vec, e);
                end
                if (k == 4) a_set_req = 1'b0;
                if (k == 9) a_clr_req = 1'b0;
            end
        end
    endtask

    task automatic test_err();
        logic [5:0] e;
        // Stuck latch: mismatch in CHECK, err visible the cycle after.
        a_stuck = 1'b1;
        a_set_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            e = exp_op(k, 2, 1, 1'b1, k >= 5);
            n_checks++;
            if (a_vec !== e) begin
                n_fail++; $display("FAIL err_stuck k=%0d got %b want %b", k, a_vec, e);
            end
            if (k == 4) a_set_req = 1'b0;
        end
        // Good operation: err stays sticky.
        a_stuck = 1'b0;
        a_clr_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            e = exp_op(k, 2, 1, 1'b0, 1'b1);
            n_checks++;
            if (a_vec !== e) begin
                n_fail++; $display("FAIL err_sticky k=%0d got %b want %b", k, a_vec, e);
            end
            if (k == 4) a_clr_req = 1'b0;
        end
        // Clean-cycle clear.
        a_err_clr = 1'b1;
        step();
        a_err_clr = 1'b0;
        n_checks++;
        if (a_err !== 1'b0) begin
            n_fail++; $display("FAIL err_clr_clean got %b want 0", a_err);
        end
        // err_clr in the same cycle as a mismatching CHECK: set wins.
        a_stuck = 1'b1;
        a_set_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            e = exp_op(k, 2, 1, 1'b1, k >= 5);
            n_checks++;
            if (a_vec !== e) begin
                n_fail++; $display("FAIL err_coincide k=%0d got %b want %b", k, a_vec, e);
            end
            a_err_clr = (k == 4);
            if (k == 4) a_set_req = 1'b0;
        end
        a_stuck = 1'b0;
        a_err_clr = 1'b1;
        step();
        a_err_clr = 1'b0;
        n_checks++;
        if (a_err !== 1'b0) begin
            n_fail++; $display("FAIL err_clr_final got %b want 0", a_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] e;
        a_set_req = 1'b1;
        step();
        e = exp_op(1, 2, 1, 1'b1, 1'b0);
        n_checks++;
        if (a_vec !== e) begin
            n_fail++; $display("FAIL rstmid_pulse got %b want %b", a_vec, e);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (a_vec !== 6'b0) begin
            n_fail++; $display("FAIL rstmid_async got %b want %b", a_vec, 6'b0);
        end
        step();
        n_checks++;
        if (a_vec !== 6'b0) begin
            n_fail++; $display("FAIL rstmid_noack got %b want %b", a_vec, 6'b0);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            e = exp_op(k, 2, 1, 1'b1, 1'b0);
            n_checks++;
            if (a_vec !== e) begin
                n_fail++; $display("FAIL rstmid_restart k=%0d got %b want %b", k, a_vec, e);
            end
            if (k == 4) a_set_req = 1'b0;
        end
    endtask

    task automatic test_random();
        int reqs = 0;
        int acks = 0;
        int stray = 0;
        for (int c = 0; c < 1060; c++) begin
            step();
            n_checks++;
            if ((a_lat_s & a_lat_r) !== 1'b0 || a_err !== 1'b0 || (a_set_ack & a_clr_ack) !== 1'b0) begin
                n_fail++;
                $display("FAIL random_inv c=%0d s=%b r=%b sa=%b ca=%b err=%b want s&r=0 err=0",
                         c, a_lat_s, a_lat_r, a_set_ack, a_clr_ack, a_err);
            end
            if (a_set_ack) begin
                if (!a_set_req) stray++;
                a_set_req = 1'b0;
                acks++;
            end else if (!a_set_req && c < 1000 && $urandom_range(0, 3) == 0) begin
                a_set_req = 1'b1;
                reqs++;
            end
            if (a_clr_ack) begin
                if (!a_clr_req) stray++;
                a_clr_req = 1'b0;
                acks++;
            end else if (!a_clr_req && c < 1000 && $urandom_range(0, 3) == 0) begin
                a_clr_req = 1'b1;
                reqs++;
            end
        end
        n_checks++;
        if (a_set_req || a_clr_req) begin
            n_fail++; $display("FAIL random_drain timeout set_req=%b clr_req=%b want both 0", a_set_req, a_clr_req);
        end
        n_checks++;
        if (acks != reqs) begin
            n_fail++; $display("FAIL random_count acks=%0d want %0d", acks, reqs);
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++; $display("FAIL random_stray_ack got %0d want 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fast();
        test_reset();
        test_tie();
        test_reset();
        test_err();
        test_reset_mid();
        test_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_latch_ctrl.md
# sr_latch_ctrl

Synchronous sequencer that owns the S/R inputs of one gate-level SR latch and shares it between two requesters: a set requester and a clear requester. It drives fixed-width S or R pulses, never both high at once. It then waits a settle gap and checks the latch's Q/NQ feedback. It acknowledges each operation and raises a sticky error flag when the latch does not reach the commanded state.

## Interface
Parameters:
- PULSE_W, 2, cycles S or R is held high per operation (legal 1..15)
- GAP_W, 1, settle cycles with S=R=0 before checking feedback (legal 0..15)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- set_req  in  1  level request to drive latch to Q=1; held until set_ack
- clr_req  in  1  level request to drive latch to Q=0; held until clr_ack
- err_clr  in  1  synchronous clear of err
- lat_q  in  1  latch Q feedback
- lat_nq  in  1  latch NQ feedback
- lat_s  out  1  latch S drive, registered
- lat_r  out  1  latch R drive, registered
- set_ack  out  1  one-cycle completion strobe for a set operation
- clr_ack  out  1  one-cycle completion strobe for a clear operation
- busy  out  1  high in every state except IDLE
- err  out  1  sticky feedback-mismatch flag

## Operation
- States: IDLE, PULSE, SETTLE, CHECK. One 4-bit down-counter is shared by PULSE and SETTLE.
- IDLE: requests are sampled only here.
  - Only one request high: grant it.
  - Both high: grant the opposite of last_grant (round-robin). After reset, last_grant=clear, so the first tie grants set.
  - On grant: register the grant, load the counter with PULSE_W-1, go to PULSE.
- PULSE:
  - lat_s=1 for a set grant, lat_r=1 for a clear grant, for exactly PULSE_W cycles.
  - On exit: load the counter with GAP_W-1 and go to SETTLE, or go straight to CHECK if GAP_W=0.
- SETTLE: lat_s=lat_r=0 for GAP_W cycles, then go to CHECK.
- CHECK: lasts one cycle.
  - Assert set_ack or clr_ack, whichever matches the grant.
  - Expected Q is 1 for set, 0 for clear.
  - If lat_q≠expected or lat_q==lat_nq, set err.
  - Update last_grant and return to IDLE.
- Requester protocol:
  - Drop req on the clock edge where ack is high.
  - A req still high in the following IDLE cycle is a new request and is served.
- Requests that change while busy are ignored. No queuing.
- Invariant: lat_s & lat_r == 0 in every cycle, including across reset.
- err:
  - Set only in CHECK.
  - err_clr clears it on the next edge.
  - If err_clr coincides with a CHECK mismatch, set wins and err stays 1.
- lat_q/lat_nq are sampled only in CHECK. Glitches in other states are ignored.

## Timing
- Reset (rst_n low, async):
  - State IDLE, counter 0, last_grant=clear.
  - lat_s=lat_r=set_ack=clr_ack=busy=err=0, all immediately, without waiting for clk.
  - The latch keeps its own stored value; the controller does not re-initialise it.
- Latency, with the request sampled in IDLE at cycle 0:
  - S/R high in cycles 1..PULSE_W.
  - Gap in cycles PULSE_W+1..PULSE_W+GAP_W.
  - Ack in cycle PULSE_W+GAP_W+1.
  - Earliest next grant in cycle PULSE_W+GAP_W+2.
  - Defaults: S/R high in cycles 1–2, gap in cycle 3, ack in cycle 4, throughput one op per 5 cycles.
- busy is high from cycle 1 through the ack cycle inclusive.
- err becomes visible the cycle after CHECK.
- Reset mid-operation: S/R drop immediately, no ack is issued, the grant is discarded, and the requester must re-request.
- Counter never wraps: each load is ≤14 and the counter decrements to 0.

## Test plan
- Reset, then set_req=1 with a latch model returning Q=1/NQ=0 → lat_s=1 in cycles 1–2, lat_r=0 throughout, set_ack=1 in cycle 4 only, busy=1 in cycles 1–4, err=0.
- Follow with clr_req=1 → lat_r=1 for 2 cycles, clr_ack in cycle 4, latch model Q=0, err=0. Rerun with PULSE_W=1, GAP_W=0 → ack in cycle 2.
- After reset, set_req=clr_req=1 held (each dropped on its own ack) → set granted first (ack cycle 4), then clear (lat_r from cycle 6, ack cycle 9). A second tie afterwards grants set again.
- Faulty latch stuck Q=0/NQ=0, then set_req → err=1 from cycle 5 and held through later good ops. err_clr pulse in the same cycle as a new mismatch CHECK → err stays 1. err_clr in a clean cycle → err=0.
- rst_n driven low in cycle 1 of PULSE between clock edges → lat_s falls before the next edge, no set_ack, busy=0. After release, held set_req restarts the full sequence.
- 1000 cycles of random set_req/clr_req with legal handshakes and a correct latch model → lat_s&lat_r never 1, ack count equals request count, err=0.
